// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO for DATA_W-bit words with registered read data.
// Overflow (write while full) and underflow (read while empty) requests are
// ignored, so stored data is never corrupted.
//
// Parameters:
//   DATA_W - word width (default 10)
//   DEPTH  - number of entries, power of two and >= 2 (default 8)
//
// Ports:
//   clk   in   clock, all state updates on the rising edge
//   rst   in   asynchronous reset, active-low
//   Din   in   write data, sampled when a write is accepted
//   wr_en in   write request
//   rd_en in   read request
//   Dout  out  registered read data, changes only on an accepted read or reset
//   empty out  FIFO holds 0 words
//   full  out  FIFO holds DEPTH words
module sync_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] Dout,
    output logic              empty,
    output logic              full
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic wr_acc;
    logic rd_acc;

    // Flags come straight from the registered occupancy count.
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (ADDR_W+1)'(DEPTH));

    // A read on an empty FIFO is refused even if a write arrives in the same
    // cycle, so a new word is never read through combinationally.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;

        if (wr_acc) begin
            wp_d = wp_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rp_d   = rp_q + ADDR_W'(1);
            dout_d = mem_q[rp_q];
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // Storage is not reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wp_q] <= Din;
        end
    end

    assign Dout = dout_q;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] Din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] Dout;
    logic              empty;
    logic              full;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .Din  (Din),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .Dout (Dout),
        .empty(empty),
        .full (full)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: words pushed when a write is driven into a non-full model,
    // popped as the expected Dout when a read is driven into a non-empty model.
    logic [DATA_W-1:0] sb_q [$];
    logic [DATA_W-1:0] exp_dout;

    typedef struct {
        bit                wr;
        bit                rd;
        logic [DATA_W-1:0] din;
        bit                e_empty;
        bit                e_full;
        logic [DATA_W-1:0] e_dout;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus, then compare against the scoreboard.
    task automatic cycle(input bit w, input bit r, input logic [DATA_W-1:0] d);
        bit wacc;
        bit racc;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        Din   = d;
        wacc  = w && (sb_q.size() < DEPTH);
        racc  = r && (sb_q.size() > 0);
        @(posedge clk);
        #1;
        if (racc) exp_dout = sb_q.pop_front();
        if (wacc) sb_q.push_back(d);
        check("sb.dout",  32'(Dout),  32'(exp_dout));
        check("sb.empty", 32'(empty), 32'(sb_q.size() == 0));
        check("sb.full",  32'(full),  32'(sb_q.size() == DEPTH));
    endtask

    function automatic void add(input bit w, input bit r, input int d,
                                input bit e, input bit f, input int o);
        vec_t v;
        v.wr      = w;
        v.rd      = r;
        v.din     = DATA_W'(d);
        v.e_empty = e;
        v.e_full  = f;
        v.e_dout  = DATA_W'(o);
        tbl.push_back(v);
    endfunction

    initial begin
        rst      = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        Din      = '0;
        exp_dout = '0;

        // Reset state before any clock edge.
        #2;
        check("rst.dout",  32'(Dout),  32'd0);
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.full",  32'(full),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 1'b1, '0);   // read while empty after reset: Dout stays 0

        // Basic order, drain/underflow, full/overflow, simultaneous while empty.
        //   wr rd din empty full dout
        add(1, 0, 0,  0, 0, 0);
        add(1, 0, 1,  0, 0, 0);
        add(1, 0, 2,  0, 0, 0);
        add(1, 0, 3,  0, 0, 0);
        add(1, 0, 4,  0, 0, 0);
        add(0, 1, 0,  0, 0, 0);
        add(0, 1, 0,  0, 0, 1);
        add(0, 1, 0,  0, 0, 2);
        add(0, 1, 0,  0, 0, 3);
        add(0, 1, 0,  1, 0, 4);
        add(0, 1, 0,  1, 0, 4);
        for (int k = 0; k < 7; k++) add(1, 0, 10 + k, 0, 0, 4);
        add(1, 0, 17, 0, 1, 4);
        add(1, 0, 99, 0, 1, 4);
        for (int k = 0; k < 7; k++) add(0, 1, 0, 0, 0, 10 + k);
        add(0, 1, 0,  1, 0, 17);
        add(1, 1, 5,  0, 0, 17);
        add(0, 1, 0,  1, 0, 5);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].wr, tbl[i].rd, tbl[i].din);
            check($sformatf("tbl[%0d].dout", i),  32'(Dout),  32'(tbl[i].e_dout));
            check($sformatf("tbl[%0d].empty", i), 32'(empty), 32'(tbl[i].e_empty));
            check($sformatf("tbl[%0d].full", i),  32'(full),  32'(tbl[i].e_full));
        end

        // Wrap-around with simultaneous read and write, 3 words held.
        cycle(1'b1, 1'b0, 10'd50);
        cycle(1'b1, 1'b0, 10'd51);
        cycle(1'b1, 1'b0, 10'd52);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b1, DATA_W'(62 + k));
            check("wrap.empty", 32'(empty), 32'd0);
            check("wrap.full",  32'(full),  32'd0);
        end
        check("wrap.last_dout", 32'(Dout), 32'd68);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, '0);
        check("wrap.drained", 32'(Dout), 32'd71);
        check("wrap.empty_end", 32'(empty), 32'd1);

        // Simultaneous read and write while full: read only.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 1'b0, DATA_W'(20 + k));
        check("full.before", 32'(full), 32'd1);
        cycle(1'b1, 1'b1, 10'd88);
        check("full.rw_dout", 32'(Dout), 32'd20);
        check("full.rw_full", 32'(full), 32'd0);
        for (int k = 0; k < DEPTH - 1; k++) cycle(1'b0, 1'b1, '0);
        check("full.drain_dout", 32'(Dout), 32'd27);
        check("full.drain_empty", 32'(empty), 32'd1);

        // Mid-operation asynchronous reset while full.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 1'b0, DATA_W'(40 + k));
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst.dout",  32'(Dout),  32'd0);
        check("midrst.empty", 32'(empty), 32'd1);
        check("midrst.full",  32'(full),  32'd0);
        sb_q.delete();
        exp_dout = '0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 1'b1, '0);
        check("midrst.rd_dout", 32'(Dout), 32'd0);
        cycle(1'b1, 1'b0, 10'd7);
        cycle(1'b0, 1'b1, '0);
        check("midrst.after", 32'(Dout), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer for 10-bit data words, with registered read data and full/empty status flags. It decouples a producer and a consumer that share one clock, absorbing bursts of up to DEPTH words. Overflow and underflow attempts are ignored, so no stored data is ever corrupted.

## Interface
- DATA_W, default 10: word width of Din and Dout.
- DEPTH, default 8: number of storage entries. Must be a power of two and at least 2.
- ADDR_W, default log2(DEPTH) = 3: pointer width, derived from DEPTH and not set independently.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low. The port keeps the codebase name `rst`, but low means reset.
- Din  input  DATA_W  write data, sampled on a rising edge when a write is accepted.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- Dout  output  DATA_W  registered read data.
- empty  output  1  high when the FIFO holds 0 words.
- full  output  1  high when the FIFO holds DEPTH words.

## Operation
- Storage:
  - DEPTH x DATA_W register array.
  - Write pointer wp and read pointer rp, each ADDR_W bits.
  - Occupancy counter cnt, ADDR_W+1 bits, range 0..DEPTH.
- Write accepted when `wr_en & ~full`:
  - mem[wp] <= Din.
  - wp <= wp+1, wrapping modulo DEPTH.
- Read accepted when `rd_en & ~empty`:
  - Dout <= mem[rp].
  - rp <= rp+1, wrapping modulo DEPTH.
- Blocked requests:
  - wr_en while full is ignored; memory, wp and cnt are unchanged.
  - rd_en while empty is ignored; Dout holds its previous value and rp is unchanged.
- Simultaneous accepted read and write in one cycle:
  - Both pointers advance and cnt is unchanged.
  - If the FIFO is empty, only the write is accepted. The new word is not read through in the same cycle.
  - If the FIFO is full, only the read is accepted. The write is dropped.
- Counter update:
  - Write only: cnt+1.
  - Read only: cnt-1.
  - Both or neither: unchanged.
- Flags are decoded combinationally from the registered cnt:
  - empty = (cnt == 0).
  - full = (cnt == DEPTH).
- Dout changes only on an accepted read or on reset.
- Ordering: words leave in exactly the order they were accepted, including across pointer wrap-around.

## Timing
- Reset (rst low, asynchronous assert, takes effect without waiting for clk):
  - wp = rp = 0, cnt = 0.
  - Dout = 0, empty = 1, full = 0.
  - Memory contents are not cleared and are don't-care.
- Reset release is sampled synchronously: the first operation is possible on the first rising edge with rst high.
- Reset asserted mid-operation discards all stored words immediately; flags return to empty=1 and full=0.
- Write latency:
  - Word is stored on the accepting edge.
  - empty deasserts after that same edge.
  - The word is readable from the next cycle.
- Read latency: Dout shows the word after the edge on which rd_en & ~empty was sampled, i.e. 1 cycle.
- Flag update:
  - full asserts after the edge that accepts the DEPTH-th word.
  - full deasserts after the edge of the first accepted read.
  - empty behaves symmetrically.
- Handshake: no ready/valid protocol beyond the flags. The producer checks full and the consumer checks empty before asserting a request. Holding wr_en or rd_en high performs one transfer per cycle.

## Test plan
- Reset: drive rst low mid-run -> immediately Dout=0, empty=1, full=0. Then release and read with rd_en=1 -> Dout stays 0.
- Basic order: write 0,1,2,3,4 on single-cycle wr_en pulses, then 4 single-cycle rd_en pulses -> Dout = 0,1,2,3 in turn. empty stays 0 because one word remains.
- Drain and underflow: read the remaining word -> Dout=4 and empty=1. Pulse rd_en again -> Dout stays 4.
- Full and overflow: write 8 words 10..17 -> full=1 after the 8th edge. Write 99 -> ignored. Read 8 times -> 10..17, and 99 never appears.
- Wrap-around plus simultaneous access: with 3 words held, assert wr_en and rd_en together for 10 cycles writing 62,63,... -> cnt stays 3, data order is preserved across the pointer wrap, and full and empty both stay 0.
- Edge cases: wr_en and rd_en together while empty -> write only, Dout unchanged, empty=0. wr_en and rd_en together while full -> read only, full=0 afterwards.
